// File: rtl/gpsdo_pkg.sv
// Shared types and default constants for the GPSDO phase measurement path.
package gpsdo_pkg;

    localparam int PHASE_W = 24;

    typedef logic [PHASE_W-1:0] phase_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } avg_state_e;

    localparam phase_t      MAX_PHASE_DEF      = 24'd10_000_000;
    localparam logic [31:0] TIMEOUT_CYCLES_DEF = 32'd12_000_000;

endpackage

// File: rtl/edge_rise_det.sv
// Registered rising-edge detector; RST_VAL = 1 suppresses a false edge when the
// input is already high as reset releases.
module edge_rise_det #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic CLK_SYS,
    input  logic CLK_RST,
    input  logic sig,
    output logic rise
);

    logic sig_d;

    always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
        if (!CLK_RST) begin
            sig_d <= RST_VAL;
        end else begin
            sig_d <= sig;
        end
    end

    assign rise = sig & ~sig_d;

endmodule

// File: rtl/phase_avg.sv
// Phase-count averager with capture-loss timeout for the GPSDO loop.
// Optional outlier rejection against the last average: PHASE_OUTLIER_REJECT_EN.
//
// state | meaning
// IDLE  | no window open; first accepted capture opens one
// ACCUM | summing accepted captures until 2^AVG_LOG2 are held
// DONE  | one cycle: publish average, pulse Avg_Valid, reopen window
module phase_avg
    import gpsdo_pkg::*;
#(
    parameter int unsigned AVG_LOG2       = 4,
    parameter phase_t      MAX_PHASE      = MAX_PHASE_DEF,
    parameter logic [31:0] TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`ifdef PHASE_OUTLIER_REJECT_EN
    ,
    parameter phase_t      OUTLIER_TH     = 24'd1000,
    parameter int unsigned REJECT_LIMIT   = 4
`endif
) (
    input  logic                 CLK_SYS,
    input  logic                 CLK_RST,
    input  logic [PHASE_W-1:0]   Measure_Phase,
    input  logic                 Measure_Done,
    output logic [PHASE_W-1:0]   Avg_Phase,
    output logic                 Avg_Valid,
    output logic [AVG_LOG2:0]    Sample_Cnt,
    output logic                 Gps_Lost,
    output logic [7:0]           Reject_Cnt
);

    localparam int ACC_W = PHASE_W + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_FULL = {1'b1, {AVG_LOG2{1'b0}}};

    avg_state_e         state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   cnt_inc;
    phase_t             avg_q, avg_d;
    logic               valid_q, valid_d;
    logic               lost_q, lost_d;
    logic [7:0]         rej_q, rej_d;
    logic [31:0]        to_q, to_d;

    logic               capture;
    logic               in_range;
    logic               accept;
    logic               to_term;

    edge_rise_det #(
        .RST_VAL (1'b1)
    ) u_done_det (
        .CLK_SYS (CLK_SYS),
        .CLK_RST (CLK_RST),
        .sig     (Measure_Done),
        .rise    (capture)
    );

    assign in_range = (Measure_Phase <= MAX_PHASE);
    assign to_term  = (to_q == TIMEOUT_CYCLES - 32'd1);
    assign cnt_inc  = cnt_q + CNT_ONE;

`ifdef PHASE_OUTLIER_REJECT_EN
    logic                      exists_q, exists_d;
    logic [7:0]                consec_q, consec_d;
    logic signed [PHASE_W:0]   diff;
    logic [PHASE_W:0]          diff_mag;
    logic                      outlier;
    logic                      force_idle;

    assign diff     = $signed({1'b0, Measure_Phase}) - $signed({1'b0, avg_q});
    assign diff_mag = diff[PHASE_W] ? $unsigned(-diff) : $unsigned(diff);
    assign outlier  = exists_q && (diff_mag > {1'b0, OUTLIER_TH});
    assign accept   = capture && in_range && !outlier;
`else
    assign accept   = capture && in_range;
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        avg_d   = avg_q;
        valid_d = 1'b0;
        lost_d  = lost_q;
        rej_d   = rej_q;
        to_d    = to_q;
`ifdef PHASE_OUTLIER_REJECT_EN
        exists_d   = exists_q;
        consec_d   = consec_q;
        force_idle = 1'b0;
`endif

        // Rejected captures still prove the GPS side is alive.
        if (capture) begin
            to_d   = '0;
            lost_d = 1'b0;
            if (!accept && rej_q != 8'hFF) begin
                rej_d = rej_q + 8'd1;
            end
        end else if (!to_term) begin
            to_d = to_q + 32'd1;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    acc_d   = ACC_W'(Measure_Phase);
                    cnt_d   = CNT_ONE;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_d = acc_q + ACC_W'(Measure_Phase);
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_FULL) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                avg_d   = acc_q[AVG_LOG2 +: PHASE_W];
                valid_d = 1'b1;
                acc_d   = '0;
                cnt_d   = '0;
                state_d = ACCUM;
`ifdef PHASE_OUTLIER_REJECT_EN
                exists_d = 1'b1;
`endif
            end
            default: state_d = IDLE;
        endcase

`ifdef PHASE_OUTLIER_REJECT_EN
        if (capture && in_range) begin
            if (outlier) begin
                consec_d = consec_q + 8'd1;
                if (consec_q == 8'(REJECT_LIMIT - 1)) begin
                    force_idle = 1'b1;
                end
            end else begin
                consec_d = '0;
            end
        end
        if (force_idle) begin
            state_d  = IDLE;
            acc_d    = '0;
            cnt_d    = '0;
            exists_d = 1'b0;
            consec_d = '0;
        end
`endif

        if (to_term && !capture) begin
            lost_d  = 1'b1;
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
`ifdef PHASE_OUTLIER_REJECT_EN
            exists_d = 1'b0;
            consec_d = '0;
`endif
        end
    end

    always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
        if (!CLK_RST) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            avg_q   <= '0;
            valid_q <= 1'b0;
            lost_q  <= 1'b0;
            rej_q   <= '0;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            avg_q   <= avg_d;
            valid_q <= valid_d;
            lost_q  <= lost_d;
            rej_q   <= rej_d;
            to_q    <= to_d;
        end
    end

`ifdef PHASE_OUTLIER_REJECT_EN
    always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
        if (!CLK_RST) begin
            exists_q <= 1'b0;
            consec_q <= '0;
        end else begin
            exists_q <= exists_d;
            consec_q <= consec_d;
        end
    end
`endif

    assign Avg_Phase  = avg_q;
    assign Avg_Valid  = valid_q;
    assign Sample_Cnt = cnt_q;
    assign Gps_Lost   = lost_q;
    assign Reject_Cnt = rej_q;

endmodule
